// File: rtl/fetch_pkg.sv
// Shared widths, reset default and the buffered fetch entry type for the
// instruction fetch unit and its response FIFO.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // The instruction memory is word addressed; the byte offset is dropped.
  function automatic logic [XLEN-1:0] word_address(input logic [XLEN-1:0] byte_pc);
    return {2'b00, byte_pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular response buffer between instruction memory and decode.
// flush empties it in one cycle; stored entries are left in place.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        pushData,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        headData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= pushData;
    end
  end

  assign count    = count_q;
  assign headData = mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  // The issuer only fetches when a slot is guaranteed, so a push into a full buffer is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !pop && (count_q == CW'(DEPTH))));
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, one-deep in-flight tracking and redirect handling in front
// of a 1-cycle synchronous instruction memory; results go to decode via a FIFO.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [XLEN-1:0]    instructionAddress,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirectValid,
  input  logic [XLEN-1:0]    redirectTarget,
  input  logic               decodeReady,
  output logic               fetchValid,
  output logic [INSTR_W-1:0] fetchInstruction,
  output logic [XLEN-1:0]    fetchPc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_in_flight_q, pc_in_flight_d;
  logic            in_flight_q, in_flight_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head_data;
  logic            push, pop, issue;
  logic [1:0]      unused_target_bits;

  assign unused_target_bits = redirectTarget[1:0];

  assign fetchValid = (fifo_count != '0) && !redirectValid;
  assign pop        = fetchValid && decodeReady;
  assign push       = in_flight_q && !redirectValid;

  // Slots already claimed after this cycle's pop; the in-flight read counts as one.
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(in_flight_q) - (CW + 1)'(pop);
  assign issue     = !redirectValid && (occupancy < (CW + 1)'(FIFO_DEPTH));

  always_comb begin
    pc_d           = pc_q;
    in_flight_d    = 1'b0;
    pc_in_flight_d = pc_in_flight_q;
    if (redirectValid) begin
      pc_d = {redirectTarget[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d           = pc_q + 32'd4;
      in_flight_d    = 1'b1;
      pc_in_flight_d = pc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q           <= {RESET_PC[XLEN-1:2], 2'b00};
      pc_in_flight_q <= '0;
      in_flight_q    <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      pc_in_flight_q <= pc_in_flight_d;
      in_flight_q    <= in_flight_d;
    end
  end

  assign push_data = '{instr: instruction, pc: pc_in_flight_q};

  fetch_skid_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (reset),
    .push     (push),
    .pushData (push_data),
    .pop      (pop),
    .flush    (redirectValid),
    .count    (fifo_count),
    .headData (head_data)
  );

  assign instructionAddress = word_address(pc_q);
  assign fetchInstruction   = head_data.instr;
  assign fetchPc            = head_data.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: memory word k holds 32'h1000_0000+k; each task checks one
// scenario cycle by cycle against hand-derived pc/instruction values.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        decodeReady;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [31:0] fetchPc;

  int tests_run    = 0;
  int tests_failed = 0;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .redirectValid      (redirectValid),
    .redirectTarget     (redirectTarget),
    .decodeReady        (decodeReady),
    .fetchValid         (fetchValid),
    .fetchInstruction   (fetchInstruction),
    .fetchPc            (fetchPc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory, 1-cycle latency, no enable.
  always @(posedge clock) instruction <= 32'h1000_0000 + instructionAddress;

  always @(negedge clock)
    if (reset && fetchValid && decodeReady)
      $display("[TB] accept pc=%h instr=%h", fetchPc, fetchInstruction);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Ends 2 time units into cycle 0 after reset release.
  task automatic do_reset(input logic ready);
    reset          = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = 32'h0;
    decodeReady    = ready;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirectValid  = 1'b0;
    redirectTarget = 32'h0;
    decodeReady    = 1'b1;
    #3 reset = 1'b0;
    #2;
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", fetchValid);
    end
    tests_run++;
    if (fetchPc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_pc: got %h expected 00000000", fetchPc);
    end
    tests_run++;
    if (fetchInstruction !== 32'h0) begin
      tests_failed++; $display("FAIL reset_instr: got %h expected 00000000", fetchInstruction);
    end
    tests_run++;
    if (instructionAddress !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr: got %h expected 00000000", instructionAddress);
    end
  endtask

  // Runs straight on from test_reset: release, then 10 streaming cycles.
  task automatic test_stream();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        next_cycle();
        #1;
      end
      tests_run++;
      if (instructionAddress !== 32'(k)) begin
        tests_failed++; $display("FAIL stream_addr c%0d: got %h expected %h", k, instructionAddress, 32'(k));
      end
      tests_run++;
      if (fetchValid !== (k >= 2)) begin
        tests_failed++; $display("FAIL stream_valid c%0d: got %b expected %b", k, fetchValid, (k >= 2));
      end
      if (k >= 2) begin
        tests_run++;
        if (fetchPc !== 32'(4 * (k - 2))) begin
          tests_failed++; $display("FAIL stream_pc c%0d: got %h expected %h", k, fetchPc, 32'(4 * (k - 2)));
        end
        tests_run++;
        if (fetchInstruction !== 32'h1000_0000 + 32'(k - 2)) begin
          tests_failed++; $display("FAIL stream_instr c%0d: got %h expected %h", k, fetchInstruction, 32'h1000_0000 + 32'(k - 2));
        end
      end
    end
  endtask

  // Continues from test_stream: head is pc 32, pc register is 40.
  task automatic test_stall();
    for (int s = 0; s < 5; s++) begin
      next_cycle();
      decodeReady = 1'b0;
      #1;
      tests_run++;
      if (fetchValid !== 1'b1 || fetchPc !== 32'd32) begin
        tests_failed++; $display("FAIL stall_hold s%0d: got valid=%b pc=%h expected valid=1 pc=00000020", s, fetchValid, fetchPc);
      end
      tests_run++;
      if (instructionAddress !== 32'd10) begin
        tests_failed++; $display("FAIL stall_addr s%0d: got %h expected 0000000a", s, instructionAddress);
      end
    end
    for (int r = 0; r < 8; r++) begin
      next_cycle();
      decodeReady = 1'b1;
      #1;
      tests_run++;
      if (fetchValid !== 1'b1 || fetchPc !== 32'(32 + 4 * r)) begin
        tests_failed++; $display("FAIL stall_resume r%0d: got valid=%b pc=%h expected valid=1 pc=%h", r, fetchValid, fetchPc, 32'(32 + 4 * r));
      end
      tests_run++;
      if (fetchInstruction !== 32'h1000_0000 + 32'(8 + r)) begin
        tests_failed++; $display("FAIL stall_instr r%0d: got %h expected %h", r, fetchInstruction, 32'h1000_0000 + 32'(8 + r));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (5) begin
      next_cycle();
      #1;
    end
    tests_run++;
    if (fetchValid !== 1'b1 || fetchPc !== 32'h0 || instructionAddress !== 32'd2) begin
      tests_failed++; $display("FAIL redir_prefill: got valid=%b pc=%h addr=%h expected valid=1 pc=00000000 addr=00000002", fetchValid, fetchPc, instructionAddress);
    end
    next_cycle();
    redirectValid  = 1'b1;
    redirectTarget = 32'h0000_0103;
    decodeReady    = 1'b1;
    #1;
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_R_valid: got %b expected 0", fetchValid);
    end
    next_cycle();
    redirectValid = 1'b0;
    #1;
    tests_run++;
    if (instructionAddress !== 32'h40) begin
      tests_failed++; $display("FAIL redir_R1_addr: got %h expected 00000040", instructionAddress);
    end
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_R1_valid: got %b expected 0", fetchValid);
    end
    next_cycle();
    #1;
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_R2_valid: got %b expected 0", fetchValid);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      tests_run++;
      if (fetchValid !== 1'b1 || fetchPc !== 32'h100 + 32'(4 * i)) begin
        tests_failed++; $display("FAIL redir_deliver i%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, fetchValid, fetchPc, 32'h100 + 32'(4 * i));
      end
      tests_run++;
      if (fetchInstruction !== 32'h1000_0040 + 32'(i)) begin
        tests_failed++; $display("FAIL redir_instr i%0d: got %h expected %h", i, fetchInstruction, 32'h1000_0040 + 32'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (3) begin
      next_cycle();
      #1;
    end
    next_cycle();
    redirectValid  = 1'b1;
    redirectTarget = 32'h0000_0200;
    #1;
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_R_valid: got %b expected 0", fetchValid);
    end
    next_cycle();
    redirectTarget = 32'h0000_0300;
    #1;
    tests_run++;
    if (fetchValid !== 1'b0 || instructionAddress !== 32'h80) begin
      tests_failed++; $display("FAIL b2b_R1: got valid=%b addr=%h expected valid=0 addr=00000080", fetchValid, instructionAddress);
    end
    next_cycle();
    redirectValid = 1'b0;
    #1;
    tests_run++;
    if (fetchValid !== 1'b0 || instructionAddress !== 32'hC0) begin
      tests_failed++; $display("FAIL b2b_R2: got valid=%b addr=%h expected valid=0 addr=000000c0", fetchValid, instructionAddress);
    end
    next_cycle();
    #1;
    tests_run++;
    if (fetchValid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_R3_valid: got %b expected 0", fetchValid);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      tests_run++;
      if (fetchValid !== 1'b1 || fetchPc !== 32'h300 + 32'(4 * i)) begin
        tests_failed++; $display("FAIL b2b_deliver i%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, fetchValid, fetchPc, 32'h300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b1);
    repeat (4) begin
      next_cycle();
      #1;
    end
    repeat (3) begin
      next_cycle();
      decodeReady = 1'b0;
      #1;
    end
    tests_run++;
    if (fetchValid !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_prefill: got %b expected 1", fetchValid);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    tests_run++;
    if (fetchValid !== 1'b0 || fetchPc !== 32'h0 || fetchInstruction !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_clear: got valid=%b pc=%h instr=%h expected 0/00000000/00000000", fetchValid, fetchPc, fetchInstruction);
    end
    tests_run++;
    if (instructionAddress !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_addr: got %h expected 00000000", instructionAddress);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    decodeReady = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        next_cycle();
        #1;
      end
      tests_run++;
      if (instructionAddress !== 32'(k) || fetchValid !== (k >= 2)) begin
        tests_failed++; $display("FAIL midrst_restart c%0d: got addr=%h valid=%b expected addr=%h valid=%b", k, instructionAddress, fetchValid, 32'(k), (k >= 2));
      end
      if (k >= 2) begin
        tests_run++;
        if (fetchPc !== 32'(4 * (k - 2))) begin
          tests_failed++; $display("FAIL midrst_pc c%0d: got %h expected %h", k, fetchPc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc    [3];
    logic [31:0] exp_instr [3];
    exp_pc    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_instr = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
    do_reset(1'b1);
    next_cycle();
    redirectValid  = 1'b1;
    redirectTarget = 32'hFFFF_FFF8;
    #1;
    repeat (2) begin
      next_cycle();
      redirectValid = 1'b0;
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      tests_run++;
      if (fetchValid !== 1'b1 || fetchPc !== exp_pc[i]) begin
        tests_failed++; $display("FAIL wrap_pc i%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, fetchValid, fetchPc, exp_pc[i]);
      end
      tests_run++;
      if (fetchInstruction !== exp_instr[i]) begin
        tests_failed++; $display("FAIL wrap_instr i%0d: got %h expected %h", i, fetchInstruction, exp_instr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
